mem_fifo_ctrl: RTL and testbench
================================

MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

Interface
REQ-001 SHALL have parameter M, 8, data word width in bits.
REQ-002 SHALL have parameter K, 4, memory address width; depth D = 2^K words.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  M  write-side word.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  controller accepts in_data this cycle.
REQ-008 out_data  output  M  head word, from holding register.
REQ-009 out_valid  output  1  holding register full.
REQ-010 out_ready  input  1  consumer takes out_data this cycle.
REQ-011 mem_din  output  M  to memory data-in.
REQ-012 mem_we  output  1  to memory write-enable; write on posedge clk.
REQ-013 mem_addr  output  K  to memory address.
REQ-014 mem_dout  input  M  from memory data-out; combinational read of mem[mem_addr].
REQ-015 count  output  K+1  stored words, memory plus holding register (max D+1).

Function
REQ-016 Pop SHALL occur when out_valid && out_ready.
REQ-017 Refill cycle SHALL occur when mem_cnt > 0 and (!out_valid or pop); drive mem_addr = rd_ptr, mem_we = 0, in_ready = 0; at the edge, load mem_dout into the holding register, rd_ptr++, mem_cnt--.
REQ-018 Otherwise, in_ready SHALL be 1 iff mem_cnt < D; if in_valid && in_ready, drive mem_we = 1, mem_addr = wr_ptr, mem_din = in_data; at the edge, wr_ptr++, mem_cnt++.
REQ-019 Refill SHALL take priority over writes; a read and a write SHALL never share a cycle.
REQ-020 in_ready SHALL be combinational from state, out_valid and out_ready; mem_we and mem_addr SHALL be combinational from state, in_valid and out_ready.
REQ-021 Pointers SHALL wrap modulo D (D-1 -> 0); FIFO order SHALL be preserved across wraps.
REQ-022 Full: mem_cnt == D forces in_ready = 0. Empty: count == 0 forces out_valid = 0.
REQ-023 Pop without refill (mem_cnt == 0) SHALL clear out_valid at the edge.
REQ-024 Latency: a word accepted into an empty controller SHALL appear at out_valid 2 edges after acceptance.
REQ-025 In idle cycles (no refill, no accepted write), mem_we SHALL be 0 and mem_addr SHALL equal wr_ptr.

Reset
REQ-026 While rst_n = 0, the block SHALL force wr_ptr = rd_ptr = 0, mem_cnt = 0, out_valid = 0, out_data = 0, count = 0, in_ready = 0, mem_we = 0 and mem_addr = 0, immediately and without waiting for clk.
REQ-027 Reset mid-operation SHALL discard all stored words; memory contents SHALL NOT be cleared.

Configuration
REQ-028 With macro MEM_FIFO_BYPASS_EN defined: when count == 0 and in_valid, accept in_data straight into the holding register (mem_we = 0, out_valid at the next edge, 1-cycle latency).
REQ-029 Without MEM_FIFO_BYPASS_EN, every word SHALL pass through memory per REQ-017/018.

Structure
REQ-030 Default M and K SHALL be defined in shared package mem_fifo_pkg; the block needs no typedefs.
REQ-031 The K-bit wrapping pointer SHALL be sub-module wrap_ctr (inc, async clear), instantiated twice.
REQ-032 The block SHALL NOT instantiate the memory; the bench connects the mem_* ports to memoryV1 #(M,K).

Verification (M = 8, K = 4)
REQ-033 Reset, then push 0x7F once -> mem_we = 1, mem_addr = 0, mem_din = 0x7F in the accept cycle; out_valid = 1 and out_data = 0x7F after 2 edges; count = 1.
REQ-034 out_ready = 0, push 0x00..0x10 -> all 17 words accepted, count = 17, then in_ready = 0; drain -> out_data 0x00..0x10 in order, count = 0.
REQ-035 Streaming 40 words with random in_valid/out_ready -> mem_addr wraps 15 -> 0, output order exact, no loss, no duplication.
REQ-036 out_valid = 1, out_ready = 1, mem_cnt = 3 -> in_ready = 0, mem_we = 0, next word on out_data after one edge, out_valid stays 1.
REQ-037 rst_n pulled low mid-cycle with count = 5 -> out_valid, in_ready and mem_we go to 0 before the next clk edge; after release, first push 0x55 lands at mem_addr 0.
REQ-038 With MEM_FIFO_BYPASS_EN, push 0xAA into empty -> mem_we stays 0, out_valid = 1 and out_data = 0xAA after 1 edge.

Source files
------------

// File: rtl/mem_fifo_pkg.sv
// Shared default sizing for the memory-backed FIFO controller.
package mem_fifo_pkg;
    localparam int MEM_FIFO_M = 8;  // data word width
    localparam int MEM_FIFO_K = 4;  // memory address width, depth = 2**K
endpackage

// File: rtl/memoryV1.sv
// Simple word memory: synchronous write, combinational read of mem[addr]; never cleared.
module memoryV1 #(
    parameter int M = 8,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         we,
    input  logic [K-1:0] addr,
    input  logic [M-1:0] din,
    output logic [M-1:0] dout
);
    logic [M-1:0] r_mem [0:(1<<K)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
    end

    assign dout = r_mem[addr];
endmodule

// File: rtl/wrap_ctr.sv
// K-bit pointer that advances on i_inc and wraps modulo 2**K; cleared by async reset.
module wrap_ctr #(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [K-1:0] o_cnt
);
    logic [K-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + K'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller over an external single-port memory plus one output holding register.
// Optional MEM_FIFO_BYPASS_EN: a word offered to an empty controller skips memory.
module mem_fifo_ctrl
    import mem_fifo_pkg::*;
#(
    parameter int M = MEM_FIFO_M,
    parameter int K = MEM_FIFO_K
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [M-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] mem_din,
    output logic         mem_we,
    output logic [K-1:0] mem_addr,
    input  logic [M-1:0] mem_dout,
    output logic [K:0]   count
);
    localparam logic [K:0] DEPTH = {1'b1, {K{1'b0}}};

    logic [K-1:0] w_wr_ptr;
    logic [K-1:0] w_rd_ptr;
    logic [K:0]   r_mem_cnt;
    logic         r_out_valid;
    logic [M-1:0] r_out_data;
    logic         w_refill;
    logic         w_in_ready;
    logic         w_accept;
    logic         w_bypass;
    logic         w_write;
    logic         w_pop;

    // The holding register is refilled whenever it is empty or being popped; that read owns the memory port.
    assign w_pop      = r_out_valid && out_ready;
    assign w_refill   = (r_mem_cnt != '0) && (!r_out_valid || out_ready);
    // rst_n gate keeps the handshake quiet during reset even though the state already reads empty.
    assign w_in_ready = rst_n && !w_refill && (r_mem_cnt != DEPTH);
    assign w_accept   = in_valid && w_in_ready;

`ifdef MEM_FIFO_BYPASS_EN
    assign w_bypass = w_accept && (r_mem_cnt == '0) && !r_out_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_write = w_accept && !w_bypass;

    wrap_ctr #(.K(K)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_write),
        .o_cnt (w_wr_ptr)
    );

    wrap_ctr #(.K(K)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_refill),
        .o_cnt (w_rd_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_refill) begin
            r_mem_cnt   <= r_mem_cnt - (K+1)'(1);
            r_out_valid <= 1'b1;
            r_out_data  <= mem_dout;
        end else begin
            if (w_write) begin
                r_mem_cnt <= r_mem_cnt + (K+1)'(1);
            end
            if (w_bypass) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign mem_we    = w_write;
    assign mem_addr  = w_refill ? w_rd_ptr : w_wr_ptr;
    assign mem_din   = in_data;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_mem_cnt + {{K{1'b0}}, r_out_valid};
endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl: queue-based reference model checked every negedge plus directed literal checks.
module tb_mem_fifo_ctrl;
    localparam int M     = 8;
    localparam int K     = 4;
    localparam int DEPTH = 16;

    logic         clk;
    logic         rst_n;
    logic [M-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] mem_din;
    logic         mem_we;
    logic [K-1:0] mem_addr;
    logic [M-1:0] mem_dout;
    logic [K:0]   count;

    int total = 0;
    int bad   = 0;

    // reference model state: words in memory as a queue, holding register, address counters
    logic [M-1:0] mq[$];
    bit           m_hv = 0;
    logic [M-1:0] m_hd = '0;
    int           m_wa = 0;
    int           m_ra = 0;
    logic [M-1:0] sent_q[$];
    logic [M-1:0] got_q[$];
    bit           seen15 = 0;
    bit           saw_wrap = 0;
    bit           e_refill, e_ready, e_bypass, e_acc, e_we;
    int           e_addr;

    mem_fifo_ctrl #(.M(M), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .count     (count)
    );

    memoryV1 #(M, K) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (mem_din),
        .dout (mem_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            mq.delete();
            sent_q.delete();
            got_q.delete();
            m_hv = 0; m_hd = '0; m_wa = 0; m_ra = 0;
            seen15 = 0; saw_wrap = 0;
        end else begin
            e_refill = (mq.size() > 0) && (!m_hv || out_ready);
            e_ready  = !e_refill && (mq.size() < DEPTH);
            e_bypass = 0;
`ifdef MEM_FIFO_BYPASS_EN
            e_bypass = e_ready && in_valid && (mq.size() == 0) && !m_hv;
`endif
            e_acc  = in_valid && e_ready;
            e_we   = e_acc && !e_bypass;
            e_addr = e_refill ? m_ra : m_wa;
            chk("in_ready", 32'(in_ready), 32'(e_ready));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), e_addr);
            if (e_we) chk("mem_din", 32'(mem_din), 32'(in_data));
            chk("out_valid", 32'(out_valid), 32'(m_hv));
            if (m_hv) chk("out_data", 32'(out_data), 32'(m_hd));
            chk("count", 32'(count), mq.size() + int'(m_hv));
            if (in_valid && in_ready) sent_q.push_back(in_data);
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (mem_we && mem_addr == 4'd15) seen15 = 1;
            else if (seen15 && mem_we && mem_addr == 4'd0) saw_wrap = 1;
            if (e_refill) begin
                m_hd = mq.pop_front();
                m_hv = 1;
                m_ra = (m_ra + 1) % DEPTH;
            end else begin
                if (e_we) begin
                    mq.push_back(in_data);
                    m_wa = (m_wa + 1) % DEPTH;
                end
                if (e_bypass) begin
                    m_hv = 1;
                    m_hd = in_data;
                end else if (m_hv && out_ready) begin
                    m_hv = 0;
                end
            end
        end
    endtask

    always @(negedge clk) model_step();

    // offer one word until accepted; returns the memory port values seen in the accept cycle
    task automatic push(input logic [M-1:0] d, output logic [K-1:0] addr, output logic we,
                        output logic [M-1:0] din);
        bit done = 0;
        in_valid = 1; in_data = d; addr = '0; we = 0; din = '0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1; addr = mem_addr; we = mem_we; din = mem_din;
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("push_accept", 32'(done), 1);
        $display("push %02h addr=%0d we=%0b t=%0t", d, addr, we, $time);
    endtask

    task automatic drain();
        out_ready = 1;
        for (int i = 0; i < 64 && count != 0; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 0;
        chk("drain_empty", 32'(count), 0);
        $display("drain done count=%0d t=%0t", count, $time);
    endtask

    logic [K-1:0] a;
    logic         w;
    logic [M-1:0] dn;
    logic [M-1:0] first_word;
    int           idx;
    int           sent;
    bit           acc;
    logic [M-1:0] word;
    bit           finished;

    initial begin
        clk = 0; rst_n = 0; in_valid = 1; in_data = 8'h3C; out_ready = 0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_out_data", 32'(out_data), 0);
        @(posedge clk); @(posedge clk); #1;
        in_valid = 0; rst_n = 1;

        // first word into an empty controller
`ifdef MEM_FIFO_BYPASS_EN
        first_word = 8'hAA;
`else
        first_word = 8'h7F;
`endif
        push(first_word, a, w, dn);
        chk("first_addr", 32'(a), 0);
`ifdef MEM_FIFO_BYPASS_EN
        chk("byp_we", 32'(w), 0);
        chk("byp_ov_1edge", 32'(out_valid), 1);
        chk("byp_od_1edge", 32'(out_data), 32'hAA);
`else
        chk("first_we", 32'(w), 1);
        chk("first_din", 32'(dn), 32'h7F);
        chk("first_ov_1edge", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("first_ov_2edge", 32'(out_valid), 1);
        chk("first_od_2edge", 32'(out_data), 32'h7F);
`endif
        chk("first_count", 32'(count), 1);
        drain();

        // fill to D+1 with the consumer stalled, then drain in order
        for (int i = 0; i <= 16; i++) push(8'(i), a, w, dn);
        @(negedge clk);
        chk("full_count", 32'(count), 17);
        chk("full_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1; idx = 0;
        for (int c = 0; c < 60 && idx < 17; c++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("fill_order", 32'(out_data), idx);
                $display("pop %02h t=%0t", out_data, $time);
                idx++;
            end
            @(posedge clk); #1;
        end
        out_ready = 0;
        chk("fill_pops", idx, 17);
        chk("fill_count_end", 32'(count), 0);

        // pop with refill pending: write blocked, next word after one edge
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), a, w, dn);
        in_valid = 1; in_data = 8'hEE; out_ready = 1;
        @(negedge clk);
        chk("pr_in_ready", 32'(in_ready), 0);
        chk("pr_mem_we", 32'(mem_we), 0);
        chk("pr_out_data", 32'(out_data), 32'hA0);
        @(posedge clk); #1;
        in_valid = 0;
        chk("pr_ov_after", 32'(out_valid), 1);
        chk("pr_od_after", 32'(out_data), 32'hA1);
        drain();

        // asynchronous reset in mid-cycle with five words stored
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), a, w, dn);
        chk("ar_count5", 32'(count), 5);
        in_valid = 1; in_data = 8'h33;
        #1;
        chk("ar_we_before", 32'(mem_we), 1);
        #1;
        rst_n = 0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 0);
        chk("ar_in_ready", 32'(in_ready), 0);
        chk("ar_mem_we", 32'(mem_we), 0);
        chk("ar_count", 32'(count), 0);
        @(posedge clk); #1;
        rst_n = 1; in_valid = 0;
        push(8'h55, a, w, dn);
        chk("ar_first_addr", 32'(a), 0);
        drain();

        // randomized stream of 40 words
        sent = 0; acc = 0; word = 8'($urandom); finished = 0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            if (acc) begin
                sent++;
                word = 8'($urandom);
            end
            finished = (sent == 40) && (mq.size() == 0) && !m_hv;
            in_valid  = (sent < 40) && ($urandom_range(0, 3) != 0);
            in_data   = word;
            out_ready = (sent >= 40) || ($urandom_range(0, 9) < 4);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 0;
        chk("stream_finished", 32'(finished), 1);
        chk("stream_sent", sent_q.size(), 41);
        chk("stream_got", got_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size() && i < got_q.size(); i++)
            chk("stream_order", 32'(got_q[i]), 32'(sent_q[i]));
        $display("stream words=%0d popped=%0d t=%0t", sent_q.size(), got_q.size(), $time);
`ifndef MEM_FIFO_BYPASS_EN
        chk("stream_wrap", 32'(saw_wrap), 1);
`endif
        chk("end_count", 32'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
